// File: rtl/rule_packer_32_64_pkg.sv
// rule_packer_32_64_pkg: shared widths, empty-slot constant and packing states
package rule_packer_32_64_pkg;
  localparam int RULE_W = 32;
  localparam int BEAT_W = 64;
  localparam logic [RULE_W-1:0] RULE_NONE = '0;
  typedef enum logic [1:0] {EMPTY, HALF, FLUSH} state_e;
endpackage

// File: rtl/rule_out_reg_64.sv
// rule_out_reg_64: single-stage valid/ready register slice for 64-bit beats with sop/eop
module rule_out_reg_64
  import rule_packer_32_64_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic              i_sop,
  input  logic              i_eop,
  input  logic [BEAT_W-1:0] i_data,
  output logic              o_can_load,
  output logic              o_valid,
  output logic              o_sop,
  output logic              o_eop,
  output logic [BEAT_W-1:0] o_data,
  input  logic              i_ready
);
  logic              r_valid;
  logic              r_sop;
  logic              r_eop;
  logic [BEAT_W-1:0] r_data;
  assign o_can_load = !r_valid | i_ready;
  assign o_valid    = r_valid;
  assign o_sop      = r_sop;
  assign o_eop      = r_eop;
  assign o_data     = r_data;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_valid <= 1'b0;
      r_sop   <= 1'b0;
      r_eop   <= 1'b0;
      r_data  <= '0;
    end else if (o_can_load) begin
      r_valid <= i_valid;
      if (i_valid) begin
        r_sop  <= i_sop;
        r_eop  <= i_eop;
        r_data <= i_data;
      end
    end
  end
endmodule

// File: rtl/rule_packer_32_64.sv
// rule_packer_32_64: packs 32-bit rule IDs two per 64-bit beat, closing each packet with an all-zero eop beat
module rule_packer_32_64
  import rule_packer_32_64_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_rule_sop,
  input  logic              in_rule_eop,
  input  logic              in_rule_valid,
  input  logic [RULE_W-1:0] in_rule_data,
  input  logic [1:0]        in_rule_empty,
  output logic              in_rule_ready,
  output logic              out_rule_sop,
  output logic              out_rule_eop,
  output logic              out_rule_valid,
  output logic [BEAT_W-1:0] out_rule_data,
  output logic [2:0]        out_rule_empty,
  input  logic              out_rule_ready,
  output logic              proto_err
);
  state_e            r_state;
  logic [RULE_W-1:0] r_lo;
  logic              r_sop_pend;
  logic              r_proto_err;
  logic              w_can_load;
  logic              w_acc;
  logic              w_miss;
  logic              w_half;
  logic              w_rule;
  logic              w_flush_go;
  logic              w_emit_pair;
  logic              w_emit_part;
  logic              w_emit_term;
  logic              w_emit;
  logic              w_sop;
  logic [BEAT_W-1:0] w_emit_data;
  logic              w_unused;
  assign w_unused       = ^in_rule_empty;
  assign in_rule_ready  = (r_state != FLUSH) & w_can_load;
  assign out_rule_empty = 3'd0;
  assign proto_err      = r_proto_err;
  always_comb begin
    w_acc       = in_rule_valid & in_rule_ready;
    w_rule      = !in_rule_eop & (in_rule_data != RULE_NONE);
    // a new sop without a preceding eop abandons the held half and restarts as EMPTY
    w_miss      = w_acc & in_rule_sop & !in_rule_eop & (r_state == HALF);
    w_half      = (r_state == HALF) & !w_miss;
    w_flush_go  = (r_state == FLUSH) & w_can_load;
    w_emit_pair = w_acc & w_rule & w_half;
    w_emit_part = w_acc & in_rule_eop & w_half;
    w_emit_term = w_flush_go | (w_acc & in_rule_eop & !w_half);
    w_emit      = w_emit_pair | w_emit_part | w_emit_term;
    w_emit_data = w_emit_term ? '0 : {w_emit_pair ? in_rule_data : RULE_NONE, r_lo};
    w_sop       = r_sop_pend | w_miss;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= EMPTY;
      r_lo        <= '0;
      r_sop_pend  <= 1'b1;
      r_proto_err <= 1'b0;
    end else begin
      if (w_flush_go)
        r_state <= EMPTY;
      else if (w_acc)
        r_state <= in_rule_eop ? (w_half ? FLUSH : EMPTY) :
                   w_rule ? (w_half ? EMPTY : HALF) :
                   w_miss ? EMPTY : r_state;
      if (w_acc & w_rule & !w_half)
        r_lo <= in_rule_data;
      r_sop_pend  <= w_emit ? w_emit_term : w_sop;
      r_proto_err <= w_miss;
    end
  end
  rule_out_reg_64 u_out (
    .clk        (clk),
    .rst        (rst),
    .i_valid    (w_emit),
    .i_sop      (w_sop),
    .i_eop      (w_emit_term),
    .i_data     (w_emit_data),
    .o_can_load (w_can_load),
    .o_valid    (out_rule_valid),
    .o_sop      (out_rule_sop),
    .o_eop      (out_rule_eop),
    .o_data     (out_rule_data),
    .i_ready    (out_rule_ready)
  );
endmodule

// File: tb/tb_rule_packer_32_64.sv
// tb_rule_packer_32_64: directed and randomized packets checked against a packet-level reference model
module tb_rule_packer_32_64;
  typedef struct {
    logic        s;
    logic        e;
    logic [31:0] d;
  } word_t;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_rule_sop = 1'b0;
  logic        in_rule_eop = 1'b0;
  logic        in_rule_valid = 1'b0;
  logic [31:0] in_rule_data = '0;
  logic [1:0]  in_rule_empty = '0;
  logic        in_rule_ready;
  logic        out_rule_sop;
  logic        out_rule_eop;
  logic        out_rule_valid;
  logic [63:0] out_rule_data;
  logic [2:0]  out_rule_empty;
  logic        out_rule_ready = 1'b1;
  logic        proto_err;
  int n_tests = 0;
  int n_fail = 0;
  int rmode = 0;
  int gap_max = 0;
  int cyc = 0;
  int rdy_low = 0;
  int err_seen = 0;
  int exp_err = 0;
  logic [71:0] exp_q[$];
  logic        m_has = 1'b0;
  logic        m_sop = 1'b1;
  logic [31:0] m_lo = '0;
  rule_packer_32_64 dut (
    .clk            (clk),
    .rst            (rst),
    .in_rule_sop    (in_rule_sop),
    .in_rule_eop    (in_rule_eop),
    .in_rule_valid  (in_rule_valid),
    .in_rule_data   (in_rule_data),
    .in_rule_empty  (in_rule_empty),
    .in_rule_ready  (in_rule_ready),
    .out_rule_sop   (out_rule_sop),
    .out_rule_eop   (out_rule_eop),
    .out_rule_valid (out_rule_valid),
    .out_rule_data  (out_rule_data),
    .out_rule_empty (out_rule_empty),
    .out_rule_ready (out_rule_ready),
    .proto_err      (proto_err)
  );
  always #5 clk = ~clk;
  function automatic logic [71:0] mk(input logic s, input logic e, input logic [63:0] d);
    return {6'd0, s, e, d};
  endfunction
  task automatic chk(input string tag, input logic [79:0] got, input logic [79:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask
  // Reference: collect rules of the current packet, pair them in arrival order, close with a zero eop beat
  task automatic model(input word_t w);
    if (w.s && !w.e && m_has) begin
      exp_err++;
      m_has = 1'b0;
      m_sop = 1'b1;
    end
    if (w.e) begin
      if (m_has) begin
        exp_q.push_back(mk(m_sop, 1'b0, {32'h0, m_lo}));
        m_sop = 1'b0;
        m_has = 1'b0;
      end
      exp_q.push_back(mk(m_sop, 1'b1, 64'h0));
      m_sop = 1'b1;
    end else if (w.d != 0) begin
      if (m_has) begin
        exp_q.push_back(mk(m_sop, 1'b0, {w.d, m_lo}));
        m_sop = 1'b0;
        m_has = 1'b0;
      end else begin
        m_lo  = w.d;
        m_has = 1'b1;
      end
    end
  endtask
  task automatic model_reset();
    exp_q.delete();
    m_has = 1'b0;
    m_sop = 1'b1;
  endtask
  always @(posedge clk) begin
    #1;
    cyc++;
    out_rule_ready = rmode == 0 ? 1'b1 :
                     rmode == 1 ? (cyc[0] && !((cyc % 24) inside {[6:10]})) :
                     rmode == 2 ? ($urandom_range(0, 2) != 0) : 1'b0;
  end
  logic [71:0] cur;
  logic [71:0] pb;
  logic        pv = 1'b0;
  logic        pr = 1'b0;
  always @(negedge clk) begin
    cur = mk(out_rule_sop, out_rule_eop, out_rule_data);
    if (rst) pv = 1'b0;
    else begin
      if (pv && !pr) chk("stall_hold", {7'd0, out_rule_valid, cur}, {7'd0, 1'b1, pb});
      if (!in_rule_ready) rdy_low++;
      if (proto_err) err_seen++;
      if (out_rule_valid && out_rule_ready) begin
        chk("out_empty", {77'd0, out_rule_empty}, 80'd0);
        if (exp_q.size() == 0) chk("extra_beat", 80'(exp_q.size()), 80'd1);
        else chk("beat", {8'd0, cur}, {8'd0, exp_q.pop_front()});
      end
      pv = out_rule_valid;
      pr = out_rule_ready;
      pb = cur;
    end
  end
  // Called just after a rising edge; returns just after the accepting edge
  task automatic send(input word_t w);
    int t;
    repeat ($urandom_range(0, gap_max)) begin
      @(posedge clk);
      #1;
    end
    in_rule_valid = 1'b1;
    in_rule_sop   = w.s;
    in_rule_eop   = w.e;
    in_rule_data  = w.d;
    in_rule_empty = 2'($urandom);
    t = 0;
    forever begin
      @(negedge clk);
      if (in_rule_ready) break;
      t++;
      if (t > 1000) begin
        chk("in_ready_timeout", 80'(t), 80'd0);
        in_rule_valid = 1'b0;
        return;
      end
    end
    model(w);
    @(posedge clk);
    #1;
    in_rule_valid = 1'b0;
    in_rule_sop   = 1'b0;
    in_rule_eop   = 1'b0;
    in_rule_data  = $urandom;
  endtask
  task automatic send_pkt(input word_t q[$]);
    foreach (q[i]) send(q[i]);
  endtask
  task automatic drain(input string tag);
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_left"}, 80'(exp_q.size()), 80'd0);
    chk({tag, "_err"}, 80'(err_seen), 80'(exp_err));
    @(posedge clk);
    #1;
  endtask
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_valid", {79'd0, out_rule_valid}, 80'd0);
    chk("rst_beat", {8'd0, mk(out_rule_sop, out_rule_eop, out_rule_data)}, 80'd0);
    chk("rst_err", {79'd0, proto_err}, 80'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask
  word_t pkt[$];
  initial begin
    #3;
    chk("init_valid", {79'd0, out_rule_valid}, 80'd0);
    chk("init_beat", {8'd0, mk(out_rule_sop, out_rule_eop, out_rule_data)}, 80'd0);
    chk("init_err", {79'd0, proto_err}, 80'd0);
    chk("init_in_ready", {79'd0, in_rule_ready}, 80'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    // test 1
    rdy_low = 0;
    pkt = '{'{1, 0, 32'h11}, '{0, 0, 32'h22}, '{0, 0, 32'h33}, '{0, 1, 32'h0}};
    send_pkt(pkt);
    drain("t1");
    chk("t1_bubble", 80'(rdy_low), 80'd1);
    // test 2
    pkt = '{'{1, 1, 32'h0}};
    send_pkt(pkt);
    drain("t2");
    // test 3
    pkt = '{'{1, 0, 32'h5}, '{0, 0, 32'h0}, '{0, 0, 32'h0}, '{0, 0, 32'h6}, '{0, 1, 32'hdead}};
    send_pkt(pkt);
    drain("t3");
    // test 4
    rmode = 1;
    pkt = '{'{1, 0, 32'h11}, '{0, 0, 32'h22}, '{0, 0, 32'h33}, '{0, 1, 32'h0}};
    repeat (3) send_pkt(pkt);
    drain("t4");
    rmode = 0;
    // test 5
    pkt = '{'{1, 0, 32'h7}, '{1, 0, 32'h9}, '{0, 1, 32'h0}};
    send_pkt(pkt);
    drain("t5");
    // test 6: stalled in-flight beat, then held half, both lost to reset
    rmode = 3;
    pkt = '{'{1, 0, 32'h3}, '{0, 0, 32'h4}};
    send_pkt(pkt);
    @(posedge clk);
    #1;
    chk("t6_stalled", {79'd0, out_rule_valid}, 80'd1);
    async_reset();
    rmode = 0;
    pkt = '{'{1, 0, 32'hAB}};
    send_pkt(pkt);
    async_reset();
    pkt = '{'{1, 0, 32'h1}, '{0, 0, 32'h2}, '{0, 1, 32'h0}};
    send_pkt(pkt);
    drain("t6");
    // randomized packets with backpressure, idle gaps and missing eops
    rmode = 2;
    gap_max = 2;
    for (int p = 0; p < 60; p++) begin
      int n;
      n = $urandom_range(0, 5);
      pkt.delete();
      for (int i = 0; i < n; i++)
        pkt.push_back('{i == 0, 1'b0, ($urandom_range(0, 3) == 0) ? 32'h0 : $urandom});
      if (n == 0 || $urandom_range(0, 5) != 0) pkt.push_back('{n == 0, 1'b1, $urandom});
      send_pkt(pkt);
    end
    pkt = '{'{1, 1, 32'h0}};
    send_pkt(pkt);
    drain("rand");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
